ram_bank_scheduler: RTL and testbench
=====================================

RAM_BANK_SCHEDULER -- requirements
Module: ram_bank_scheduler

Interface
REQ-001 SHALL have ports: clk, in, 1, system clock; all state is updated on its rising edge.
REQ-002 SHALL have ports: rst, in, 1, asynchronous active-low reset.
REQ-003 SHALL have ports: prod_req, in, 1, producer access request; each acked cycle is one byte write.
REQ-004 SHALL have ports: prod_addr, in, 14, producer byte address within the bank.
REQ-005 SHALL have ports: prod_wdata, in, 8, producer write byte.
REQ-006 SHALL have ports: prod_ack, out, 1, producer write accepted this cycle.
REQ-007 SHALL have ports: prod_done, in, 1, single-cycle pulse marking the current write bank as a complete page.
REQ-008 SHALL have ports: cons_req, in, 1, consumer read request.
REQ-009 SHALL have ports: cons_addr, in, 14, consumer byte address within the bank.
REQ-010 SHALL have ports: cons_ack, out, 1, consumer read accepted this cycle.
REQ-011 SHALL have ports: cons_rvalid, out, 1, cons_rdata is valid; asserted one cycle after cons_ack.
REQ-012 SHALL have ports: cons_rdata, out, 8, read byte.
REQ-013 SHALL have ports: cons_done, in, 1, single-cycle pulse releasing the current read bank.
REQ-014 SHALL have ports: ram0_en, ram0_we, out, 1 each, enable and write strobe for bank 0 (synchronous RAM, read latency 1).
REQ-015 SHALL have ports: ram0_addr, out, 14, bank 0 address.
REQ-016 SHALL have ports: ram0_din, out, 8, bank 0 write data.
REQ-017 SHALL have ports: ram0_dout, in, 8, bank 0 read data.
REQ-018 SHALL have ports: ram1_en, ram1_we, ram1_addr, ram1_din, ram1_dout, with widths 1, 1, 14, 8, 8 and the same meanings for bank 1.
REQ-019 SHALL have ports: full_cnt, out, 2, number of full banks (0..2).
REQ-020 SHALL have ports: err_ovf, err_udf, out, 1 each, single-cycle error pulses.

Function
REQ-021 SHALL keep state wr_bank (1b), rd_bank (1b) and full[1:0].
- full[b]=1 means bank b holds a completed page that has not yet been consumed.
REQ-022 SHALL drive prod_ack = prod_req AND NOT full[wr_bank], combinationally.
REQ-023 SHALL assert, on prod_ack, ram<wr_bank>_en=1 and _we=1, and drive _addr=prod_addr and _din=prod_wdata in the same cycle.
REQ-024 SHALL drive cons_ack = cons_req AND full[rd_bank], combinationally.
REQ-025 SHALL assert, on cons_ack, ram<rd_bank>_en=1 and _we=0, and drive _addr=cons_addr.
REQ-026 SHALL register the bank selected by rd_bank on cons_ack.
- On the next cycle: cons_rvalid=1 and cons_rdata = dout of the registered bank.
- Otherwise: cons_rvalid=0 and cons_rdata holds its last value.
REQ-027 SHALL drive ramX_en/we/addr/din to 0 for a bank not accessed this cycle.
REQ-028 SHALL, on prod_done with full[wr_bank]=0: set full[wr_bank] and toggle wr_bank on the next edge.
REQ-029 SHALL, on prod_done with full[wr_bank]=1: change no state and pulse err_ovf for one cycle.
REQ-030 SHALL, on cons_done with full[rd_bank]=1: clear full[rd_bank] and toggle rd_bank.
REQ-031 SHALL, on cons_done with full[rd_bank]=0: change no state and pulse err_udf for one cycle.
REQ-032 SHALL evaluate simultaneous prod_done and cons_done against pre-edge state; both updates apply in the same edge.
REQ-033 SHALL ignore a prod_req or cons_req that arrives in the same cycle as its own done pulse with respect to bank switching.
- The access itself uses the pre-edge bank.
REQ-034 SHALL never enable both ports on the same bank in one cycle.
- This follows from REQ-022/024: a bank cannot be both full and not full.
REQ-035 SHALL set full_cnt = full[0]+full[1], registered, updated together with full.

Reset
REQ-036 SHALL, while rst=0, force wr_bank=0, rd_bank=0, full=00, full_cnt=0, cons_rvalid=0, cons_rdata=0, err_ovf=0 and err_udf=0.
- It SHALL also gate prod_ack, cons_ack and all ramX_en/we to 0 regardless of requests.
REQ-037 SHALL discard, on reset assertion mid-operation, any in-flight read (no cons_rvalid after release) and all page ownership.

Verification
REQ-038 SHALL cover fill and drain:
- Stimulus: 4 producer writes (addr 0..3, data A0..A3), prod_done, then 4 consumer reads.
- Response: writes go to ram0; full_cnt=1; reads hit ram0; cons_rdata=A0..A3 each one cycle after ack; after cons_done full_cnt=0, wr_bank=rd_bank=1.
REQ-039 SHALL cover backpressure:
- Stimulus: fill and complete both banks, then prod_req=1.
- Response: prod_ack=0 and full_cnt=2; a further prod_done pulses err_ovf and leaves full_cnt=2.
REQ-040 SHALL cover underflow:
- Stimulus: cons_req=1 and cons_done from reset.
- Response: cons_ack=0 and err_udf pulses once; state stays unchanged.
REQ-041 SHALL cover concurrent access:
- Stimulus: bank 0 full; producer writes bank 1 while the consumer reads bank 0 in the same cycles.
- Response: both acks=1, ram0 read-only and ram1 write-only; simultaneous prod_done+cons_done gives full=10, wr_bank=0, rd_bank=1.
REQ-042 SHALL cover reset mid-read:
- Stimulus: rst low in the cycle after cons_ack.
- Response: cons_rvalid=0; after release full_cnt=0 and prod_ack follows prod_req.

Source files
------------

// File: rtl/ram_bank_scheduler.sv
// ram_bank_scheduler
//   Ping-pong scheduler for two single-port synchronous byte RAM banks.
//   A producer fills one bank while a consumer drains the other. A bank is
//   handed over by done pulses and tracked with a per-bank "full" flag.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   prod_req/addr/wdata/ack   producer byte-write handshake
//   prod_done                 marks the current write bank as a complete page
//   cons_req/addr/ack         consumer byte-read handshake
//   cons_rvalid/rdata         read data, one cycle after cons_ack
//   cons_done                 releases the current read bank
//   ram0_*/ram1_*             bank strobes, address, write data, read data
//   full_cnt                  number of full banks (0..2)
//   err_ovf/err_udf           one-cycle pulses for a done that cannot apply
module ram_bank_scheduler #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_req,
  input  logic [ADDR_W-1:0] prod_addr,
  input  logic [DATA_W-1:0] prod_wdata,
  output logic              prod_ack,
  input  logic              prod_done,
  input  logic              cons_req,
  input  logic [ADDR_W-1:0] cons_addr,
  output logic              cons_ack,
  output logic              cons_rvalid,
  output logic [DATA_W-1:0] cons_rdata,
  input  logic              cons_done,
  output logic              ram0_en,
  output logic              ram0_we,
  output logic [ADDR_W-1:0] ram0_addr,
  output logic [DATA_W-1:0] ram0_din,
  input  logic [DATA_W-1:0] ram0_dout,
  output logic              ram1_en,
  output logic              ram1_we,
  output logic [ADDR_W-1:0] ram1_addr,
  output logic [DATA_W-1:0] ram1_din,
  input  logic [DATA_W-1:0] ram1_dout,
  output logic [1:0]        full_cnt,
  output logic              err_ovf,
  output logic              err_udf
);

  logic       wr_bank;
  logic       rd_bank;
  logic [1:0] full;
  logic [1:0] full_nxt;

  logic prod_commit;
  logic prod_ovf;
  logic cons_commit;
  logic cons_udf;

  logic              vld_p1;
  logic              rd_bank_p1;
  logic [DATA_W-1:0] rdata_hold_p1;
  logic [DATA_W-1:0] rdata_mux;

  // ---- stage p0: handshakes and bank strobes (combinational) ----
  // The reset term keeps both acks, and therefore every RAM strobe, low
  // while rst is asserted, whatever the requests are doing.
  assign prod_ack = rst & prod_req & ~full[wr_bank];
  assign cons_ack = rst & cons_req &  full[rd_bank];

  // A write needs an empty bank and a read needs a full one, so the two
  // accesses can never land on the same bank in one cycle.
  always_comb begin
    ram0_en   = 1'b0;
    ram0_we   = 1'b0;
    ram0_addr = '0;
    ram0_din  = '0;
    ram1_en   = 1'b0;
    ram1_we   = 1'b0;
    ram1_addr = '0;
    ram1_din  = '0;
    if (prod_ack) begin
      if (wr_bank) begin
        ram1_en   = 1'b1;
        ram1_we   = 1'b1;
        ram1_addr = prod_addr;
        ram1_din  = prod_wdata;
      end else begin
        ram0_en   = 1'b1;
        ram0_we   = 1'b1;
        ram0_addr = prod_addr;
        ram0_din  = prod_wdata;
      end
    end
    if (cons_ack) begin
      if (rd_bank) begin
        ram1_en   = 1'b1;
        ram1_addr = cons_addr;
      end else begin
        ram0_en   = 1'b1;
        ram0_addr = cons_addr;
      end
    end
  end

  // Done pulses are judged against pre-edge state. A successful prod_done
  // needs full[wr_bank]=0 and a successful cons_done needs full[rd_bank]=1,
  // so when both succeed they always touch different banks.
  assign prod_commit = prod_done &  ~full[wr_bank];
  assign prod_ovf    = prod_done &   full[wr_bank];
  assign cons_commit = cons_done &   full[rd_bank];
  assign cons_udf    = cons_done &  ~full[rd_bank];

  always_comb begin
    full_nxt = full;
    if (prod_commit) full_nxt[wr_bank] = 1'b1;
    if (cons_commit) full_nxt[rd_bank] = 1'b0;
  end

  // ---- stage p1: bank ownership, error pulses, read return ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_bank       <= 1'b0;
      rd_bank       <= 1'b0;
      full          <= 2'b00;
      full_cnt      <= 2'd0;
      err_ovf       <= 1'b0;
      err_udf       <= 1'b0;
      vld_p1        <= 1'b0;
      rdata_hold_p1 <= '0;
    end else begin
      full     <= full_nxt;
      full_cnt <= {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
      if (prod_commit) wr_bank <= ~wr_bank;
      if (cons_commit) rd_bank <= ~rd_bank;
      err_ovf <= prod_ovf;
      err_udf <= cons_udf;
      vld_p1  <= cons_ack;
      // Remember the returned byte so cons_rdata holds it between reads.
      if (vld_p1) rdata_hold_p1 <= rdata_mux;
    end
  end

  // The bank a read targeted is only needed while its data returns.
  always_ff @(posedge clk) begin
    if (cons_ack) rd_bank_p1 <= rd_bank;
  end

  assign rdata_mux   = rd_bank_p1 ? ram1_dout : ram0_dout;
  assign cons_rvalid = vld_p1;
  assign cons_rdata  = vld_p1 ? rdata_mux : rdata_hold_p1;

endmodule

// File: tb/tb_ram_bank_scheduler.sv
module tb_ram_bank_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        prod_req, prod_done, cons_req, cons_done;
  logic [13:0] prod_addr, cons_addr;
  logic [7:0]  prod_wdata;
  logic        prod_ack, cons_ack, cons_rvalid;
  logic [7:0]  cons_rdata;
  logic        ram0_en, ram0_we, ram1_en, ram1_we;
  logic [13:0] ram0_addr, ram1_addr;
  logic [7:0]  ram0_din, ram1_din;
  logic [7:0]  ram0_dout, ram1_dout;
  logic [1:0]  full_cnt;
  logic        err_ovf, err_udf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_bank_scheduler dut (
    .clk(clk), .rst(rst),
    .prod_req(prod_req), .prod_addr(prod_addr), .prod_wdata(prod_wdata),
    .prod_ack(prod_ack), .prod_done(prod_done),
    .cons_req(cons_req), .cons_addr(cons_addr), .cons_ack(cons_ack),
    .cons_rvalid(cons_rvalid), .cons_rdata(cons_rdata), .cons_done(cons_done),
    .ram0_en(ram0_en), .ram0_we(ram0_we), .ram0_addr(ram0_addr),
    .ram0_din(ram0_din), .ram0_dout(ram0_dout),
    .ram1_en(ram1_en), .ram1_we(ram1_we), .ram1_addr(ram1_addr),
    .ram1_din(ram1_din), .ram1_dout(ram1_dout),
    .full_cnt(full_cnt), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  // Synchronous RAM banks, read latency 1.
  logic [7:0] mem0 [0:16383];
  logic [7:0] mem1 [0:16383];
  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    ram0_dout = 8'h00;
    ram1_dout = 8'h00;
  end
  always @(posedge clk) begin
    if (ram0_en) begin
      if (ram0_we) mem0[ram0_addr] <= ram0_din;
      ram0_dout <= mem0[ram0_addr];
    end
    if (ram1_en) begin
      if (ram1_we) mem1[ram1_addr] <= ram1_din;
      ram1_dout <= mem1[ram1_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic pr, input logic [13:0] pa, input logic [7:0] pd,
                       input logic pdn, input logic cr, input logic [13:0] ca,
                       input logic cdn);
    prod_req = pr; prod_addr = pa; prod_wdata = pd; prod_done = pdn;
    cons_req = cr; cons_addr = ca; cons_done = cdn;
  endtask

  typedef struct {
    logic pr; logic [13:0] pa; logic [7:0] pd; logic pdn;
    logic cr; logic [13:0] ca; logic cdn;
    logic e_pack; logic e_cack; logic [1:0] e_fc; logic e_ovf; logic e_udf;
    logic e_rv; logic [7:0] e_rd; logic [1:0] e_ren; logic [1:0] e_rwe;
  } vec_t;

  function automatic vec_t v(input logic pr, input int pa, input int pd, input logic pdn,
                             input logic cr, input int ca, input logic cdn,
                             input logic pack, input logic cack, input int fc,
                             input logic ovf, input logic udf, input logic rv,
                             input int rd, input int ren, input int rwe);
    vec_t r;
    r.pr = pr; r.pa = pa[13:0]; r.pd = pd[7:0]; r.pdn = pdn;
    r.cr = cr; r.ca = ca[13:0]; r.cdn = cdn;
    r.e_pack = pack; r.e_cack = cack; r.e_fc = fc[1:0]; r.e_ovf = ovf; r.e_udf = udf;
    r.e_rv = rv; r.e_rd = rd[7:0]; r.e_ren = ren[1:0]; r.e_rwe = rwe[1:0];
    return r;
  endfunction

  vec_t tab[$];

  // Reference model state: pages produced / consumed since reset.
  int         p_cnt, c_cnt;
  logic [7:0] refmem [0:1][0:63];
  logic       m_rv, m_ovf, m_udf;
  logic [7:0] m_rdata;

  initial begin
    for (int b = 0; b < 2; b++)
      for (int a = 0; a < 64; a++) refmem[b][a] = 8'h00;

    //    pr pa  pd    pdn cr ca cdn | pack cack fc ovf udf rv rd    ren rwe
    // underflow from reset
    tab.push_back(v(0, 0, 0,     0, 1, 0, 1,   0, 0, 0, 0, 0, 0, 0,     0, 0));
    tab.push_back(v(0, 0, 0,     0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0,     0, 0));
    tab.push_back(v(0, 0, 0,     0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,     0, 0));
    // fill bank 0 and drain it
    tab.push_back(v(1, 0, 'hA0,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,     1, 1));
    tab.push_back(v(1, 1, 'hA1,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,     1, 1));
    tab.push_back(v(1, 2, 'hA2,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,     1, 1));
    tab.push_back(v(1, 3, 'hA3,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0,     1, 1));
    tab.push_back(v(0, 0, 0,     1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0,     0, 0));
    tab.push_back(v(0, 0, 0,     0, 1, 0, 0,   0, 1, 1, 0, 0, 0, 0,     1, 0));
    tab.push_back(v(0, 0, 0,     0, 1, 1, 0,   0, 1, 1, 0, 0, 1, 'hA0,  1, 0));
    tab.push_back(v(0, 0, 0,     0, 1, 2, 0,   0, 1, 1, 0, 0, 1, 'hA1,  1, 0));
    tab.push_back(v(0, 0, 0,     0, 1, 3, 0,   0, 1, 1, 0, 0, 1, 'hA2,  1, 0));
    tab.push_back(v(0, 0, 0,     0, 0, 0, 1,   0, 0, 1, 0, 0, 1, 'hA3,  0, 0));
    tab.push_back(v(0, 0, 0,     0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 'hA3,  0, 0));
    // fill both banks, then backpressure and overflow
    tab.push_back(v(1, 5, 'hB5,  0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 'hA3,  2, 2));
    tab.push_back(v(0, 0, 0,     1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 'hA3,  0, 0));
    tab.push_back(v(1, 6, 'hB6,  0, 0, 0, 0,   1, 0, 1, 0, 0, 0, 'hA3,  1, 1));
    tab.push_back(v(0, 0, 0,     1, 0, 0, 0,   0, 0, 1, 0, 0, 0, 'hA3,  0, 0));
    tab.push_back(v(1, 7, 'hB7,  0, 0, 0, 0,   0, 0, 2, 0, 0, 0, 'hA3,  0, 0));
    tab.push_back(v(1, 7, 'hB7,  1, 0, 0, 0,   0, 0, 2, 0, 0, 0, 'hA3,  0, 0));
    tab.push_back(v(0, 0, 0,     0, 0, 0, 0,   0, 0, 2, 1, 0, 0, 'hA3,  0, 0));
    tab.push_back(v(0, 0, 0,     0, 0, 0, 0,   0, 0, 2, 0, 0, 0, 'hA3,  0, 0));
    // drain bank 1 so only bank 0 stays full
    tab.push_back(v(0, 0, 0,     0, 1, 5, 0,   0, 1, 2, 0, 0, 0, 'hA3,  2, 0));
    tab.push_back(v(0, 0, 0,     0, 0, 0, 1,   0, 0, 2, 0, 0, 1, 'hB5,  0, 0));
    tab.push_back(v(0, 0, 0,     0, 0, 0, 0,   0, 0, 1, 0, 0, 0, 'hB5,  0, 0));
    // concurrent write bank 1 / read bank 0, then simultaneous dones
    tab.push_back(v(1, 8, 'hC8,  0, 1, 6, 0,   1, 1, 1, 0, 0, 0, 'hB5,  3, 2));
    tab.push_back(v(1, 9, 'hC9,  1, 1, 6, 1,   1, 1, 1, 0, 0, 1, 'hB6,  3, 2));
    tab.push_back(v(0, 0, 0,     0, 0, 0, 0,   0, 0, 1, 0, 0, 1, 'hB6,  0, 0));
    tab.push_back(v(0, 0, 0,     0, 1, 8, 0,   0, 1, 1, 0, 0, 0, 'hB6,  2, 0));
    tab.push_back(v(1, 10, 'hDA, 0, 0, 0, 0,   1, 0, 1, 0, 0, 1, 'hC8,  1, 1));

    // ---- reset state ----
    rst = 1'b0;
    drive(1, 0, 8'h55, 0, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);
    chk("rst_prod_ack", prod_ack, 0);
    chk("rst_cons_ack", cons_ack, 0);
    chk("rst_ram_en",   {ram1_en, ram0_en, ram1_we, ram0_we}, 0);
    chk("rst_full_cnt", full_cnt, 0);
    chk("rst_rvalid",   cons_rvalid, 0);
    chk("rst_rdata",    cons_rdata, 0);
    chk("rst_errs",     {err_ovf, err_udf}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);

    // ---- table-driven vectors ----
    foreach (tab[i]) begin
      @(posedge clk); #1;
      drive(tab[i].pr, tab[i].pa, tab[i].pd, tab[i].pdn, tab[i].cr, tab[i].ca, tab[i].cdn);
      @(negedge clk);
      chk("tab_prod_ack", prod_ack, tab[i].e_pack);
      chk("tab_cons_ack", cons_ack, tab[i].e_cack);
      chk("tab_full_cnt", full_cnt, tab[i].e_fc);
      chk("tab_err_ovf",  err_ovf, tab[i].e_ovf);
      chk("tab_err_udf",  err_udf, tab[i].e_udf);
      chk("tab_rvalid",   cons_rvalid, tab[i].e_rv);
      chk("tab_rdata",    cons_rdata, tab[i].e_rd);
      chk("tab_ram_en",   {ram1_en, ram0_en}, tab[i].e_ren);
      chk("tab_ram_we",   {ram1_we, ram0_we}, tab[i].e_rwe);
    end

    // ---- reset in the cycle after a read is accepted ----
    // State now: bank 1 full, rd_bank=1, wr_bank=0.
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 1, 9, 0);
    @(negedge clk);
    chk("mid_cons_ack", cons_ack, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1, 12, 8'hEE, 0, 1, 9, 0);
    @(negedge clk);
    chk("mid_rst_rvalid", cons_rvalid, 0);
    chk("mid_rst_acks",   {prod_ack, cons_ack}, 0);
    chk("mid_rst_ram_en", {ram1_en, ram0_en}, 0);
    chk("mid_rst_fcnt",   full_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_rvalid", cons_rvalid, 0);
    chk("post_rst_pack",   prod_ack, 1);
    chk("post_rst_cack",   cons_ack, 0);
    chk("post_rst_ram0",   {ram0_en, ram0_we}, 2'b11);
    chk("post_rst_fcnt",   full_cnt, 0);
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("post_rst_pack_lo", prod_ack, 0);
    chk("post_rst_rv_lo",   cons_rvalid, 0);

    // ---- randomized run against the page-count model ----
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    p_cnt = 0; c_cnt = 0;
    m_rv = 0; m_ovf = 0; m_udf = 0; m_rdata = 8'h00;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic        do_rst;
      int          occ, wb, rb;
      logic        e_pack, e_cack, n_rv;
      logic [7:0]  n_rdata;
      logic [31:0] e_r0, e_r1, a_r0, a_r1;
      do_rst = ($urandom_range(0, 299) == 0);
      rst = ~do_rst;
      drive($urandom_range(0, 2) != 0, 14'(32 + $urandom_range(0, 31)), 8'($urandom),
            $urandom_range(0, 11) == 0, $urandom_range(0, 2) != 0,
            14'(32 + $urandom_range(0, 31)), $urandom_range(0, 11) == 0);
      @(negedge clk);
      if (do_rst) begin
        chk("rnd_rst_acks",  {prod_ack, cons_ack, ram0_en, ram1_en, ram0_we, ram1_we}, 0);
        chk("rnd_rst_state", {cons_rvalid, err_ovf, err_udf, full_cnt, cons_rdata}, 0);
        p_cnt = 0; c_cnt = 0;
        m_rv = 0; m_ovf = 0; m_udf = 0; m_rdata = 8'h00;
      end else begin
        occ = p_cnt - c_cnt;
        wb  = p_cnt % 2;
        rb  = c_cnt % 2;
        e_pack = prod_req && (occ < 2);
        e_cack = cons_req && (occ > 0);
        e_r0 = 0; e_r1 = 0;
        if (e_pack) begin
          if (wb == 1) e_r1 = {8'h0, 2'b11, prod_addr, prod_wdata};
          else         e_r0 = {8'h0, 2'b11, prod_addr, prod_wdata};
        end
        if (e_cack) begin
          if (rb == 1) e_r1 = {8'h0, 2'b10, cons_addr, 8'h00};
          else         e_r0 = {8'h0, 2'b10, cons_addr, 8'h00};
        end
        a_r0 = {8'h0, ram0_en, ram0_we, ram0_addr, (ram0_en && !ram0_we) ? 8'h00 : ram0_din};
        a_r1 = {8'h0, ram1_en, ram1_we, ram1_addr, (ram1_en && !ram1_we) ? 8'h00 : ram1_din};
        chk("rnd_prod_ack", prod_ack, e_pack);
        chk("rnd_cons_ack", cons_ack, e_cack);
        chk("rnd_ram0",     a_r0, e_r0);
        chk("rnd_ram1",     a_r1, e_r1);
        chk("rnd_full_cnt", full_cnt, occ);
        chk("rnd_err_ovf",  err_ovf, m_ovf);
        chk("rnd_err_udf",  err_udf, m_udf);
        chk("rnd_rvalid",   cons_rvalid, m_rv);
        chk("rnd_rdata",    cons_rdata, m_rdata);
        n_rv = e_cack;
        n_rdata = e_cack ? refmem[rb][cons_addr[5:0]] : m_rdata;
        if (e_pack) refmem[wb][prod_addr[5:0]] = prod_wdata;
        m_ovf = prod_done && (occ == 2);
        m_udf = cons_done && (occ == 0);
        if (prod_done && occ < 2) p_cnt++;
        if (cons_done && occ > 0) c_cnt++;
        m_rv = n_rv;
        m_rdata = n_rdata;
      end
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
